// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
//   Shared types and constants for the ws2812 frame streamer slice.
//   - rgb_t      : 24-bit pixel word (GRB or RGB, the streamer does not care)
//   - CHn_MSB/LSB: byte-lane slices of a pixel word, lane 2 is the top byte
//   - LED_IDX_W  : width of the pixel index handed to the ws2812 driver
//   - state_e    : streamer FSM state encodings
// ---------------------------------------------------------------------------
package ws2812_pkg;

  localparam int LED_IDX_W = 8;
  localparam int RGB_W     = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam int CH2_MSB = 23;
  localparam int CH2_LSB = 16;
  localparam int CH1_MSB = 15;
  localparam int CH1_LSB = 8;
  localparam int CH0_MSB = 7;
  localparam int CH0_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EMIT = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/ws2812_scaler.sv
// ---------------------------------------------------------------------------
// ws2812_scaler
//   Global brightness scaler: each 8-bit lane becomes (c * (b + 1)) >> 8,
//   registered once. b = 255 passes the colour through unchanged.
//   Ports:
//     clk      in   clock
//     rgb_i    in   24-bit pixel from the frame RAM read port
//     bright_i in   8-bit brightness, sampled on the same edge as rgb_i
//     rgb_o    out  scaled pixel, one cycle after rgb_i/bright_i
// ---------------------------------------------------------------------------
module ws2812_scaler
  import ws2812_pkg::*;
(
  input  logic        clk,
  input  logic [23:0] rgb_i,
  input  logic [7:0]  bright_i,
  output logic [23:0] rgb_o
);

  // Max product is 255 * 256, which still fits in 16 bits.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  rgb_t rgb_p1;

  // Stage p0 -> p1: multiply and register
  always_ff @(posedge clk) begin
    rgb_p1 <= {scale_ch(rgb_i[CH2_MSB:CH2_LSB], bright_i),
               scale_ch(rgb_i[CH1_MSB:CH1_LSB], bright_i),
               scale_ch(rgb_i[CH0_MSB:CH0_LSB], bright_i)};
  end

  assign rgb_o = rgb_p1;

endmodule

// File: rtl/ws2812_frame_streamer.sv
// ---------------------------------------------------------------------------
// ws2812_frame_streamer
//   Double-buffered frame store in front of the ws2812 bit driver. The host
//   fills the back bank, pulses commit, and the front bank is streamed out as
//   paced (led_num, rgb_data, write) transactions. One further commit may be
//   queued while a frame is streaming; extra commits merge into it.
//
//   Optional feature macro: WS2812_BRIGHTNESS_EN
//     defined   -> brightness port present, one extra scaler register stage
//     undefined -> rgb_data comes straight from the RAM read register
//
//   Ports:
//     clk         in   single clock
//     reset       in   synchronous active-high reset
//     pix_we      in   host pixel write strobe (back bank)
//     pix_addr    in   host pixel index, >= NUM_LEDS is ignored
//     pix_rgb     in   host pixel colour
//     commit      in   swap banks and stream (queued if busy)
//     brightness  in   global scale factor (WS2812_BRIGHTNESS_EN only)
//     busy        out  streaming or a commit is queued
//     frame_done  out  pulses with the write of the last pixel
//     led_num     out  pixel index to ws2812
//     rgb_data    out  pixel colour to ws2812 (0 when write is low)
//     write       out  1-cycle strobe to ws2812
// ---------------------------------------------------------------------------
module ws2812_frame_streamer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int WRITE_GAP = 64
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_we,
  input  logic [7:0]  pix_addr,
  input  logic [23:0] pix_rgb,
  input  logic        commit,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  led_num,
  output logic [23:0] rgb_data,
  output logic        write
);

  localparam int AW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int GAP_W = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;

  localparam logic [LED_IDX_W-1:0] LAST_IDX = LED_IDX_W'(NUM_LEDS - 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(WRITE_GAP - 1);

  rgb_t bank0 [NUM_LEDS];
  rgb_t bank1 [NUM_LEDS];
  rgb_t rd_p0;

  state_e               state_q, state_d;
  logic [LED_IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 bank_sel_q, bank_sel_d;
  logic                 pending_q, pending_d;

  logic host_wr;
  logic last_emit;
  logic vld_p0;
  logic done_p0;

  assign host_wr   = pix_we && (pix_addr <= LAST_IDX);
  assign last_emit = (state_q == ST_EMIT) && (idx_q == LAST_IDX);

  // Host writes always land in the bank the streamer is not reading. A write
  // in the same cycle as the swap still uses the pre-swap bank_sel_q, so it
  // lands in the bank that is about to be streamed.
  always_ff @(posedge clk) begin
    if (host_wr) begin
      if (bank_sel_q) begin
        bank0[pix_addr[AW-1:0]] <= pix_rgb;
      end else begin
        bank1[pix_addr[AW-1:0]] <= pix_rgb;
      end
    end
  end

  // Stage p0: registered read of the front bank
  always_ff @(posedge clk) begin
    if (state_q == ST_READ) begin
      rd_p0 <= bank_sel_q ? bank1[idx_q[AW-1:0]] : bank0[idx_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      bank_sel_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      bank_sel_q <= bank_sel_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    bank_sel_d = bank_sel_q;
    pending_d  = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          bank_sel_d = ~bank_sel_q;
          idx_d      = '0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (idx_q == LAST_IDX) begin
          // A commit arriving on the last write is honoured straight away
          // rather than being parked in pending.
          if (pending_q || commit) begin
            pending_d  = 1'b0;
            bank_sel_d = ~bank_sel_q;
            idx_d      = '0;
            gap_d      = GAP_LOAD;
            state_d    = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_READ;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (commit && (state_q != ST_IDLE) && !last_emit) begin
      pending_d = 1'b1;
    end
  end

  assign vld_p0  = (state_q == ST_EMIT);
  assign done_p0 = last_emit;
  assign busy    = (state_q != ST_IDLE) || pending_q;

`ifdef WS2812_BRIGHTNESS_EN
  logic                 vld_p1;
  logic                 done_p1;
  logic [LED_IDX_W-1:0] led_p1;
  logic [23:0]          scaled_p1;

  ws2812_scaler u_scaler (
    .clk      (clk),
    .rgb_i    (rd_p0),
    .bright_i (brightness),
    .rgb_o    (scaled_p1)
  );

  // Stage p0 -> p1: control delayed to line up with the scaler register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      led_p1  <= '0;
    end else begin
      vld_p1  <= vld_p0;
      done_p1 <= done_p0;
      led_p1  <= idx_q;
    end
  end

  assign write      = vld_p1;
  assign frame_done = done_p1;
  assign led_num    = led_p1;
  assign rgb_data   = vld_p1 ? scaled_p1 : 24'd0;
`else
  assign write      = vld_p0;
  assign frame_done = done_p0;
  assign led_num    = idx_q;
  assign rgb_data   = vld_p0 ? rd_p0 : 24'd0;
`endif

endmodule

// File: tb/tb_ws2812_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_ws2812_frame_streamer
//   Directed bench for ws2812_frame_streamer (NUM_LEDS=8, WRITE_GAP=64).
//   A negedge monitor logs every write transaction; each scenario task
//   drives stimulus and compares the log against hand-derived values.
// ---------------------------------------------------------------------------
module tb_ws2812_frame_streamer;

  localparam int NUM_LEDS  = 8;
  localparam int WRITE_GAP = 64;
  localparam int SPACING   = WRITE_GAP + 2;
  localparam int FRAME_BUDGET = NUM_LEDS * SPACING + 40;
`ifdef WS2812_BRIGHTNESS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_we;
  logic [7:0]  pix_addr;
  logic [23:0] pix_rgb;
  logic        commit;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif
  logic        busy;
  logic        frame_done;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  logic        write;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  int          wr_cyc [$];
  logic [7:0]  wr_led [$];
  logic [23:0] wr_rgb [$];
  logic        wr_done[$];
  logic        track_busy = 1'b0;
  logic        busy_drop  = 1'b0;

  ws2812_frame_streamer #(.NUM_LEDS(NUM_LEDS), .WRITE_GAP(WRITE_GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_we     (pix_we),
    .pix_addr   (pix_addr),
    .pix_rgb    (pix_rgb),
    .commit     (commit),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .busy       (busy),
    .frame_done (frame_done),
    .led_num    (led_num),
    .rgb_data   (rgb_data),
    .write      (write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_led.push_back(led_num);
      wr_rgb.push_back(rgb_data);
      wr_done.push_back(frame_done);
    end
    if (track_busy && (busy !== 1'b1)) busy_drop = 1'b1;
  end

  function automatic logic [23:0] pat_a(input int i);
    return 24'hA05000 + 24'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pix(input logic [7:0] a, input logic [23:0] c);
    pix_we = 1'b1; pix_addr = a; pix_rgb = c;
    tick();
    pix_we = 1'b0;
  endtask

  task automatic pulse_commit(output int t);
    commit = 1'b1;
    t = cyc;
    tick();
    commit = 1'b0;
  endtask

  task automatic clear_log();
    wr_cyc.delete(); wr_led.delete(); wr_rgb.delete(); wr_done.delete();
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int k = 0;
    while (wr_led.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (wr_led.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_we = 1'b0; pix_addr = '0; pix_rgb = '0; commit = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    repeat (3) tick();
    tests_run++;
    if ({write, busy, frame_done, led_num, rgb_data} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: write=%b busy=%b done=%b led=%0d rgb=%06h, expected all 0",
               write, busy, frame_done, led_num, rgb_data);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b write=%b, expected 0 0", busy, write);
    end
  endtask

  task automatic test_basic_frame();
    int t; bit ok;
    for (int i = 0; i < NUM_LEDS; i++) write_pix(8'(i), 24'(i + 1));
    clear_log();
    pulse_commit(t);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy: busy=%b, expected 1", busy);
    end
    wait_writes(NUM_LEDS, FRAME_BUDGET, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL basic_timeout: writes=%0d, expected %0d", wr_led.size(), NUM_LEDS);
    end else begin
      tests_run++;
      if (wr_cyc[0] - t !== LAT) begin
        tests_failed++;
        $display("FAIL basic_latency: got %0d cycles, expected %0d", wr_cyc[0] - t, LAT);
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        tests_run++;
        if (wr_led[i] !== 8'(i) || wr_rgb[i] !== 24'(i + 1) || wr_done[i] !== (i == NUM_LEDS - 1)) begin
          tests_failed++;
          $display("FAIL basic_pix%0d: led=%0d rgb=%06h done=%b, expected led=%0d rgb=%06h done=%b",
                   i, wr_led[i], wr_rgb[i], wr_done[i], i, 24'(i + 1), (i == NUM_LEDS - 1));
        end
        if (i > 0) begin
          tests_run++;
          if (wr_cyc[i] - wr_cyc[i-1] !== SPACING) begin
            tests_failed++;
            $display("FAIL basic_spacing%0d: got %0d, expected %0d", i, wr_cyc[i] - wr_cyc[i-1], SPACING);
          end
        end
      end
    end
    repeat (4) tick();
    tests_run++;
    if (busy !== 1'b0 || wr_led.size() != NUM_LEDS) begin
      tests_failed++;
      $display("FAIL basic_end: busy=%b writes=%0d, expected busy=0 writes=%0d", busy, wr_led.size(), NUM_LEDS);
    end
  endtask

  // Front is bank1 (1..8); load bank0 with pattern A, stream it and queue
  // a second commit at pixel 3 so bank1 follows without a break.
  task automatic test_commit_while_busy();
    int t; bit ok;
    logic [23:0] exp;
    for (int i = 0; i < NUM_LEDS; i++) write_pix(8'(i), pat_a(i));
    clear_log();
    busy_drop = 1'b0;
    pulse_commit(t);
    track_busy = 1'b1;
    wait_writes(4, FRAME_BUDGET, ok);
    pulse_commit(t);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL pend_busy: busy=%b, expected 1", busy);
    end
    wait_writes(2 * NUM_LEDS, 2 * FRAME_BUDGET, ok);
    track_busy = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL pend_timeout: writes=%0d, expected %0d", wr_led.size(), 2 * NUM_LEDS);
    end else begin
      for (int j = 0; j < 2 * NUM_LEDS; j++) begin
        exp = (j < NUM_LEDS) ? pat_a(j) : 24'(j - NUM_LEDS + 1);
        tests_run++;
        if (wr_led[j] !== 8'(j % NUM_LEDS) || wr_rgb[j] !== exp || wr_done[j] !== (j % NUM_LEDS == NUM_LEDS - 1)) begin
          tests_failed++;
          $display("FAIL pend_pix%0d: led=%0d rgb=%06h done=%b, expected led=%0d rgb=%06h",
                   j, wr_led[j], wr_rgb[j], wr_done[j], j % NUM_LEDS, exp);
        end
        if (j > 0) begin
          tests_run++;
          if (wr_cyc[j] - wr_cyc[j-1] !== SPACING) begin
            tests_failed++;
            $display("FAIL pend_spacing%0d: got %0d, expected %0d", j, wr_cyc[j] - wr_cyc[j-1], SPACING);
          end
        end
      end
    end
    tests_run++;
    if (busy_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL pend_busy_gap: busy dropped=%b, expected 0", busy_drop);
    end
    repeat (4) tick();
    tests_run++;
    if (busy !== 1'b0 || wr_led.size() != 2 * NUM_LEDS) begin
      tests_failed++;
      $display("FAIL pend_end: busy=%b writes=%0d, expected 0 and %0d", busy, wr_led.size(), 2 * NUM_LEDS);
    end
  endtask

  // Stream bank0 (A); rewrite back bank1 pixel 2 mid-stream, queue a commit.
  task automatic test_backbank_write();
    int t; bit ok;
    logic [23:0] exp;
    clear_log();
    pulse_commit(t);
    wait_writes(2, FRAME_BUDGET, ok);
    write_pix(8'd2, 24'hFF0000);
    pulse_commit(t);
    wait_writes(2 * NUM_LEDS, 2 * FRAME_BUDGET, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL bb_timeout: writes=%0d, expected %0d", wr_led.size(), 2 * NUM_LEDS);
    end else begin
      for (int j = 0; j < 2 * NUM_LEDS; j++) begin
        if (j < NUM_LEDS) exp = pat_a(j);
        else if (j == NUM_LEDS + 2) exp = 24'hFF0000;
        else exp = 24'(j - NUM_LEDS + 1);
        tests_run++;
        if (wr_led[j] !== 8'(j % NUM_LEDS) || wr_rgb[j] !== exp) begin
          tests_failed++;
          $display("FAIL bb_pix%0d: led=%0d rgb=%06h, expected led=%0d rgb=%06h",
                   j, wr_led[j], wr_rgb[j], j % NUM_LEDS, exp);
        end
      end
    end
    repeat (4) tick();
  endtask

  // Back bank is bank0 (A). Out-of-range write (addr 8 aliases index 0 if
  // truncated) issued together with commit must leave the frame intact.
  task automatic test_addr_oob();
    int t; bit ok;
    clear_log();
    pix_we = 1'b1; pix_addr = 8'd8; pix_rgb = 24'hDEAD00;
    pulse_commit(t);
    pix_we = 1'b0;
    wait_writes(NUM_LEDS, FRAME_BUDGET, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL oob_timeout: writes=%0d, expected %0d", wr_led.size(), NUM_LEDS);
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        tests_run++;
        if (wr_led[i] !== 8'(i) || wr_rgb[i] !== pat_a(i)) begin
          tests_failed++;
          $display("FAIL oob_pix%0d: led=%0d rgb=%06h, expected led=%0d rgb=%06h",
                   i, wr_led[i], wr_rgb[i], i, pat_a(i));
        end
      end
    end
    repeat (4) tick();
  endtask

  // Back bank is bank1 (1,2,FF0000,4..8). Write pixel 7 in the commit cycle.
  task automatic test_same_cycle_write();
    int t; bit ok;
    logic [23:0] exp;
    clear_log();
    pix_we = 1'b1; pix_addr = 8'd7; pix_rgb = 24'h123456;
    pulse_commit(t);
    pix_we = 1'b0;
    wait_writes(NUM_LEDS, FRAME_BUDGET, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL same_timeout: writes=%0d, expected %0d", wr_led.size(), NUM_LEDS);
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (i == 2) exp = 24'hFF0000;
        else if (i == 7) exp = 24'h123456;
        else exp = 24'(i + 1);
        tests_run++;
        if (wr_rgb[i] !== exp) begin
          tests_failed++;
          $display("FAIL same_pix%0d: rgb=%06h, expected %06h", i, wr_rgb[i], exp);
        end
      end
    end
    repeat (4) tick();
  endtask

  // Stream bank0 (A), queue a commit, reset in the gap after pixel 4.
  task automatic test_reset_midframe();
    int t; bit ok;
    logic [23:0] exp;
    clear_log();
    pulse_commit(t);
    wait_writes(5, FRAME_BUDGET, ok);
    repeat (5) tick();
    pulse_commit(t);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if (write !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid: write=%b busy=%b, expected 0 0", write, busy);
    end
    reset = 1'b0;
    repeat (200) tick();
    tests_run++;
    if (wr_led.size() != 5 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_quiet: writes=%0d busy=%b, expected 5 and 0", wr_led.size(), busy);
    end
    // bank_sel restarts at 0, so this commit streams bank1.
    pulse_commit(t);
    wait_writes(5 + NUM_LEDS, FRAME_BUDGET, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rst_restart_timeout: writes=%0d, expected %0d", wr_led.size(), 5 + NUM_LEDS);
    end else begin
      tests_run++;
      if (wr_cyc[5] - t !== LAT) begin
        tests_failed++;
        $display("FAIL rst_restart_lat: got %0d, expected %0d", wr_cyc[5] - t, LAT);
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (i == 2) exp = 24'hFF0000;
        else if (i == 7) exp = 24'h123456;
        else exp = 24'(i + 1);
        tests_run++;
        if (wr_led[5 + i] !== 8'(i) || wr_rgb[5 + i] !== exp) begin
          tests_failed++;
          $display("FAIL rst_restart_pix%0d: led=%0d rgb=%06h, expected led=%0d rgb=%06h",
                   i, wr_led[5 + i], wr_rgb[5 + i], i, exp);
        end
      end
    end
    repeat (4) tick();
  endtask

`ifdef WS2812_BRIGHTNESS_EN
  // Back bank is bank0 after the restart; scale pixel 0 by 128/256.
  task automatic test_brightness();
    int t; bit ok;
    write_pix(8'd0, 24'h804020);
    brightness = 8'd127;
    clear_log();
    pulse_commit(t);
    wait_writes(NUM_LEDS, FRAME_BUDGET, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL bright_timeout: writes=%0d, expected %0d", wr_led.size(), NUM_LEDS);
    end else begin
      tests_run++;
      if (wr_rgb[0] !== 24'h402010 || wr_cyc[0] - t !== 3 || wr_led[0] !== 8'd0) begin
        tests_failed++;
        $display("FAIL bright_pix0: rgb=%06h lat=%0d led=%0d, expected rgb=402010 lat=3 led=0",
                 wr_rgb[0], wr_cyc[0] - t, wr_led[0]);
      end
    end
    brightness = 8'd255;
    repeat (4) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_commit_while_busy();
    test_backbank_write();
    test_addr_oob();
    test_same_cycle_write();
    test_reset_midframe();
`ifdef WS2812_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
